// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// a read-valid strobe and sticky overflow/underflow error flags.
module fifo_sync_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    localparam int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic              inp_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inp_d,
    input  logic              write_flg,
    input  logic              read_flg,
    input  logic              err_clr,
    output logic [DATA_W-1:0] out_d,
    output logic              out_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] out_d_q, out_d_d;
    logic              out_valid_q, out_valid_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              wr_ok;
    logic              rd_ok;
    logic              ovf_set;
    logic              udf_set;

    always_comb begin
        rd_ok   = read_flg && !empty_q;
        // A write into a full FIFO is still accepted when a read frees a slot this cycle.
        wr_ok   = write_flg && (!full_q || rd_ok);
        ovf_set = write_flg && full_q && !rd_ok;
        udf_set = read_flg && empty_q;

        wptr_d  = wr_ok ? wptr_q + ADDR_W'(1) : wptr_q;
        rptr_d  = rd_ok ? rptr_q + ADDR_W'(1) : rptr_q;
        count_d = count_q + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, rd_ok};

        out_d_d     = rd_ok ? mem_q[rptr_q] : out_d_q;
        out_valid_d = rd_ok;

        // Flags track the next count so they line up with the registered count.
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);

        // A new error event takes priority over a coincident clear.
        ovf_d = ovf_set ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
        udf_d = udf_set ? 1'b1 : (err_clr ? 1'b0 : udf_q);
    end

    always_ff @(posedge inp_clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_d_q     <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= (AF_C == '0);
            ae_q        <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            out_d_q     <= out_d_d;
            out_valid_q <= out_valid_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // Storage is intentionally not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge inp_clk) begin
        if (wr_ok && !reset) begin
            mem_q[wptr_q] <= inp_d;
        end
    end

    assign out_d        = out_d_q;
    assign out_valid    = out_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
